div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
Sequencing controller between the EX stage and the iterative 32-bit divider (DIV/DIVU).
- Latches operands on a divide request and holds the divider's start handshake.
- Stalls the pipeline until the quotient and remainder return, then presents HI/LO for writeback.
- On a pipeline flush, drains and discards an in-flight divide so the divider is always back in its free state before the next request.

Parameters:
TIMEOUT, 48, maximum RUN/DRAIN cycles before the sticky error flag sets (the divider needs ≤36).
CW, 6, width of the watchdog cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ex_div_req  in  1  EX holds a DIV/DIVU instruction
ex_div_signed  in  1  1 = DIV, 0 = DIVU
ex_opr1  in  32  dividend (rs)
ex_opr2  in  32  divisor (rt)
flush  in  1  pipeline flush (exception/eret); kills the EX instruction
pipe_stall  in  1  downstream stall; the EX instruction cannot advance this cycle
div_start  out  1  to divider start
div_signed  out  1  to divider divsigned
div_opr1  out  32  to divider opr1 (latched)
div_opr2  out  32  to divider opr2 (latched)
div_ready  in  1  from divider ready
div_res  in  64  from divider res, {remainder, quotient}
stallreq  out  1  pipeline stall request
res_valid  out  1  hi_o/lo_o are valid for the current EX instruction
hi_o  out  32  remainder
lo_o  out  32  quotient
timeout_err  out  1  sticky watchdog error

Behaviour:
Reset (rst = 0, asynchronous):
- state = IDLE.
- All outputs 0: div_start, div_signed, div_opr1, div_opr2, res_valid, hi_o, lo_o, timeout_err.
- Watchdog counter = 0.

Registers and outputs:
- div_start, div_signed, div_opr1, div_opr2, hi_o, lo_o and res_valid are registered.
- stallreq is combinational:
  - 1 in RUN;
  - 1 in IDLE when ex_div_req && !flush;
  - 1 in DRAIN and FLUSHED when ex_div_req && !flush;
  - 0 otherwise.

Divider contract:
- Operands and div_start must stay stable from acceptance until div_ready.
- The divider leaves its end state only after sampling div_start = 0.
- The controller therefore never re-raises div_start in the cycle after it drops it.

States:
- IDLE:
  - On ex_div_req && !flush: latch opr1/opr2/signed, set div_start = 1, clear counter, go to RUN.
  - Otherwise stay; res_valid = 0.
- RUN:
  - div_start held at 1; counter increments.
  - flush has priority: go to DRAIN, keep div_start = 1.
  - Else on div_ready: capture hi_o = div_res[63:32] and lo_o = div_res[31:0], set res_valid = 1, set div_start = 0, go to DONE.
- DONE:
  - stallreq = 0; res_valid = 1; hi_o/lo_o held.
  - On flush: res_valid = 0, go to IDLE.
  - Else if pipe_stall: stay (same instruction still in EX).
  - Else: res_valid = 0, go to IDLE. The instruction advances this cycle.
- DRAIN:
  - div_start = 1; counter increments; result will be discarded.
  - On div_ready: div_start = 0, go to FLUSHED.
  - hi_o/lo_o are not updated.
- FLUSHED:
  - One cycle with div_start = 0 so the divider returns to free; then go to IDLE.
  - A request arriving here is stalled and is accepted from IDLE next cycle.

Watchdog:
- The counter runs in RUN and DRAIN and saturates.
- When counter == TIMEOUT, timeout_err sets and stays set until reset.
- The state machine is unaffected.

Latency:
- Divider path: accept in IDLE (cycle 0), RUN from cycle 1. With the team's DIV, div_ready rises in cycle 36 for normal operands and cycle 4 for a zero divisor.
- Controller: DONE (res_valid) begins the cycle after div_ready is seen.

Boundary conditions:
- Divisor = 0: the divider returns zeros; hi_o = lo_o = 0. The controller does not special-case it.
- flush and div_ready in the same RUN cycle: flush wins. The result is discarded, div_start drops, next state is FLUSHED.
- Reset mid-RUN: the controller returns to IDLE. The divider shares rst and resets too.

Test Plan:
- DIVU 100 / 7 → stallreq high from request until div_ready; then res_valid = 1 with hi_o = 2, lo_o = 14; stallreq low in DONE.
- DIV -7 / 2 (0xFFFFFFF9, 2) → lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
- DIVU 5 / 0 → res_valid with hi_o = lo_o = 0 within 6 cycles of the request; timeout_err stays 0.
- flush 10 cycles into RUN → stallreq drops immediately; div_start stays high until div_ready; FLUSHED then IDLE; hi_o/lo_o keep their prior values; a new DIVU 9 / 3 arriving during DRAIN is stalled, then gives lo_o = 3, hi_o = 0.
- pipe_stall held 3 cycles in DONE → res_valid and hi_o/lo_o held for 3 cycles; back-to-back DIVU 8 / 3 follows with no div_start re-raise in the cycle after the drop; result lo_o = 2, hi_o = 2.
- Stub divider never asserts div_ready → timeout_err sets after 48 RUN cycles and stays set; rst low clears it.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//   Sequencing controller between the EX stage and the iterative 32-bit
//   divider (DIV/DIVU). On a divide request it latches the operands and holds
//   the divider start handshake, stalls the pipeline until the quotient and
//   remainder come back, then presents them as HI/LO for writeback. A flush
//   while the divider is busy drains the operation and discards the result,
//   so the divider is always back in its free state before the next request.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low
//   ex_div_req     EX holds a DIV/DIVU instruction
//   ex_div_signed  1 = DIV, 0 = DIVU
//   ex_opr1        dividend (rs)
//   ex_opr2        divisor (rt)
//   flush          pipeline flush; kills the EX instruction
//   pipe_stall     downstream stall; EX instruction cannot advance this cycle
//   div_start      divider start (registered)
//   div_signed     divider signed-mode select (registered)
//   div_opr1       latched dividend to the divider
//   div_opr2       latched divisor to the divider
//   div_ready      divider result ready
//   div_res        divider result {remainder, quotient}
//   stallreq       pipeline stall request (combinational)
//   res_valid      hi_o/lo_o are valid for the current EX instruction
//   hi_o           remainder
//   lo_o           quotient
//   timeout_err    sticky watchdog error

module div_seq_ctrl #(
    parameter int TIMEOUT = 48,
    parameter int CW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_opr1,
    input  logic [31:0] ex_opr2,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opr1,
    output logic [31:0] div_opr2,
    input  logic        div_ready,
    input  logic [63:0] div_res,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DONE,
        DRAIN,
        FLUSHED
    } state_t;

    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    state_t        state, state_nx;
    logic          start_nx, signed_nx, valid_nx, err_nx;
    logic [31:0]   opr1_nx, opr2_nx, hi_nx, lo_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          new_req;

    // Watchdog count saturates at the limit so the error compare stays true.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == TMO) ? v : v + CW'(1);
    endfunction

    assign new_req = ex_div_req && !flush;

    always_comb begin
        state_nx  = state;
        start_nx  = div_start;
        signed_nx = div_signed;
        opr1_nx   = div_opr1;
        opr2_nx   = div_opr2;
        valid_nx  = res_valid;
        hi_nx     = hi_o;
        lo_nx     = lo_o;
        cnt_nx    = cnt;
        stallreq  = 1'b0;
        err_nx    = timeout_err | (cnt == TMO);

        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                stallreq = new_req;
                if (new_req) begin
                    opr1_nx   = ex_opr1;
                    opr2_nx   = ex_opr2;
                    signed_nx = ex_div_signed;
                    start_nx  = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                stallreq = 1'b1;
                cnt_nx   = sat_inc(cnt);
                if (flush) begin
                    // A flush that coincides with ready can skip draining:
                    // the divider is already at its end state.
                    if (div_ready) begin
                        start_nx = 1'b0;
                        state_nx = FLUSHED;
                    end else begin
                        state_nx = DRAIN;
                    end
                end else if (div_ready) begin
                    hi_nx    = div_res[63:32];
                    lo_nx    = div_res[31:0];
                    valid_nx = 1'b1;
                    start_nx = 1'b0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (flush || !pipe_stall) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                stallreq = new_req;
                cnt_nx   = sat_inc(cnt);
                if (div_ready) begin
                    start_nx = 1'b0;
                    state_nx = FLUSHED;
                end
            end
            FLUSHED: begin
                // Start stays low for this cycle so the divider can see the
                // drop and return to free before any new request is accepted.
                stallreq = new_req;
                start_nx = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            div_start   <= 1'b0;
            div_signed  <= 1'b0;
            div_opr1    <= '0;
            div_opr2    <= '0;
            res_valid   <= 1'b0;
            hi_o        <= '0;
            lo_o        <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            div_start   <= start_nx;
            div_signed  <= signed_nx;
            div_opr1    <= opr1_nx;
            div_opr2    <= opr2_nx;
            res_valid   <= valid_nx;
            hi_o        <= hi_nx;
            lo_o        <= lo_nx;
            cnt         <= cnt_nx;
            timeout_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl
//   Bench for div_seq_ctrl. A behavioural divider answers the start handshake
//   (ready in cycle 36 after acceptance, cycle 4 for a zero divisor, held until
//   start is seen low). Expected {hi, lo} pairs are queued when a request is
//   driven and popped when res_valid rises.

module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_req;
    logic        ex_div_signed;
    logic [31:0] ex_opr1;
    logic [31:0] ex_opr2;
    logic        flush;
    logic        pipe_stall;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opr1;
    logic [31:0] div_opr2;
    logic        dv_ready;
    logic [63:0] dv_res;
    logic        stallreq;
    logic        res_valid;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        timeout_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    bit          stub_hang = 1'b0;
    int          dcnt;

    always #5 clk = ~clk;

    div_seq_ctrl #(.TIMEOUT(48), .CW(6)) dut (
        .clk(clk),
        .rst(rst),
        .ex_div_req(ex_div_req),
        .ex_div_signed(ex_div_signed),
        .ex_opr1(ex_opr1),
        .ex_opr2(ex_opr2),
        .flush(flush),
        .pipe_stall(pipe_stall),
        .div_start(div_start),
        .div_signed(div_signed),
        .div_opr1(div_opr1),
        .div_opr2(div_opr2),
        .div_ready(dv_ready),
        .div_res(dv_res),
        .stallreq(stallreq),
        .res_valid(res_valid),
        .hi_o(hi_o),
        .lo_o(lo_o),
        .timeout_err(timeout_err)
    );

    // Behavioural iterative divider
    function automatic logic [63:0] div_calc(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_ready <= 1'b0;
            dv_res   <= 64'd0;
            dcnt     <= 0;
        end else if (dv_ready) begin
            if (!div_start) begin
                dv_ready <= 1'b0;
                dcnt     <= 0;
            end
        end else if (div_start && !stub_hang) begin
            dcnt <= dcnt + 1;
            if (dcnt + 1 == ((div_opr2 == 32'd0) ? 3 : 35)) begin
                dv_ready <= 1'b1;
                dv_res   <= div_calc(div_signed, div_opr1, div_opr2);
            end
        end
    end

    task automatic wait_valid(input int maxc, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        while (waited < maxc) begin
            @(negedge clk);
            waited++;
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        ex_div_req    = 1'b1;
        ex_div_signed = sgn;
        ex_opr1       = a;
        ex_opr2       = b;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_div_req = 1'b0; ex_div_signed = 1'b0; ex_opr1 = '0; ex_opr2 = '0;
        flush = 1'b0; pipe_stall = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({div_start, div_signed, div_opr1, div_opr2, res_valid, hi_o, lo_o, timeout_err} !== '0)
            begin n_fail++; $display("FAIL reset_outputs: got start=%b sgn=%b o1=%h o2=%h v=%b hi=%h lo=%h err=%b expected all 0",
                div_start, div_signed, div_opr1, div_opr2, res_valid, hi_o, lo_o, timeout_err); end
        n_tests++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({stallreq, div_start, res_valid} !== 3'b000)
            begin n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {stallreq, div_start, res_valid}); end
    endtask

    task automatic test_divu_basic();
        int waited; bit ok; bit stall_ok; logic [63:0] exp;
        @(negedge clk);
        drive_req(1'b0, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        #1;
        n_tests++;
        if (stallreq !== 1'b1) begin n_fail++; $display("FAIL divu_stall_on_req: got %b expected 1", stallreq); end
        @(negedge clk);
        n_tests++;
        if ({div_start, div_opr1, div_opr2} !== {1'b1, 32'd100, 32'd7})
            begin n_fail++; $display("FAIL divu_start_latch: got %b/%h/%h expected 1/00000064/00000007", div_start, div_opr1, div_opr2); end
        ex_opr1 = 32'hDEAD_BEEF;
        waited = 1; ok = 1'b0; stall_ok = 1'b1;
        while (waited < 60) begin
            @(negedge clk);
            waited++;
            if (res_valid === 1'b1) begin ok = 1'b1; break; end
            if (stallreq !== 1'b1 || div_opr1 !== 32'd100) stall_ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL divu_done_timeout: res_valid=%b expected 1 within 60 cycles", res_valid); end
        n_tests++;
        if (waited !== 37) begin n_fail++; $display("FAIL divu_latency: got %0d expected 37", waited); end
        n_tests++;
        if (!stall_ok) begin n_fail++; $display("FAIL divu_stall_hold: got stall/operand drop expected held 1/100"); end
        exp = exp_q.pop_front();
        n_tests++;
        if ({hi_o, lo_o} !== exp) begin n_fail++; $display("FAIL divu_result: got %h expected %h", {hi_o, lo_o}, exp); end
        n_tests++;
        if ({stallreq, div_start} !== 2'b00) begin n_fail++; $display("FAIL divu_done_ctrl: got %b expected 00", {stallreq, div_start}); end
        ex_div_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL divu_valid_clear: got %b expected 0", res_valid); end
    endtask

    task automatic test_div_signed();
        int waited; bit ok; logic [63:0] exp;
        @(negedge clk);
        drive_req(1'b1, 32'hFFFF_FFF9, 32'd2);
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        @(negedge clk);
        n_tests++;
        if (div_signed !== 1'b1) begin n_fail++; $display("FAIL div_signed_out: got %b expected 1", div_signed); end
        wait_valid(60, waited, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL div_signed_timeout: res_valid=%b expected 1", res_valid); end
        exp = exp_q.pop_front();
        n_tests++;
        if ({hi_o, lo_o} !== exp) begin n_fail++; $display("FAIL div_signed_result: got %h expected %h", {hi_o, lo_o}, exp); end
        ex_div_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        int waited; bit ok; bit held_ok; bit stall_ok; bit saw_ready; bit early; int zeros;
        logic [63:0] exp;
        logic [63:0] prior;
        prior = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        @(negedge clk);
        drive_req(1'b0, 32'd1000, 32'd10);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ex_div_req = 1'b0;
        #1;
        n_tests++;
        if ({stallreq, div_start} !== 2'b01)
            begin n_fail++; $display("FAIL flush_drain_entry: got stall/start %b expected 01", {stallreq, div_start}); end
        @(negedge clk);
        drive_req(1'b0, 32'd9, 32'd3);
        exp_q.push_back({32'd0, 32'd3});
        #1;
        n_tests++;
        if (stallreq !== 1'b1) begin n_fail++; $display("FAIL flush_req_in_drain: got %b expected 1", stallreq); end
        held_ok = 1'b1; stall_ok = 1'b1; saw_ready = 1'b0; early = 1'b0; zeros = 0; ok = 1'b0; waited = 0;
        while (waited < 100) begin
            @(negedge clk);
            waited++;
            if (res_valid === 1'b1) begin ok = 1'b1; break; end
            if ({hi_o, lo_o} !== prior) held_ok = 1'b0;
            if (stallreq !== 1'b1) stall_ok = 1'b0;
            if (dv_ready === 1'b1) saw_ready = 1'b1;
            if (div_start === 1'b0) begin
                zeros++;
                if (!saw_ready) early = 1'b1;
            end
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL flush_next_timeout: res_valid=%b expected 1", res_valid); end
        n_tests++;
        if (!held_ok) begin n_fail++; $display("FAIL flush_hilo_held: got %h expected %h", {hi_o, lo_o}, prior); end
        n_tests++;
        if (!stall_ok) begin n_fail++; $display("FAIL flush_stall_new_req: got drop expected stallreq 1"); end
        n_tests++;
        if (early) begin n_fail++; $display("FAIL flush_start_early_drop: got start 0 before ready expected held 1"); end
        n_tests++;
        if (zeros !== 2) begin n_fail++; $display("FAIL flush_start_gap: got %0d low cycles expected 2", zeros); end
        exp = exp_q.pop_front();
        n_tests++;
        if ({hi_o, lo_o} !== exp) begin n_fail++; $display("FAIL flush_next_result: got %h expected %h", {hi_o, lo_o}, exp); end
        ex_div_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int waited; bit ok; logic [63:0] exp;
        @(negedge clk);
        drive_req(1'b0, 32'd5, 32'd0);
        exp_q.push_back(64'd0);
        wait_valid(6, waited, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL div0_latency: res_valid=%b expected 1 within 6 cycles", res_valid); end
        exp = exp_q.pop_front();
        n_tests++;
        if ({hi_o, lo_o} !== exp) begin n_fail++; $display("FAIL div0_result: got %h expected %h", {hi_o, lo_o}, exp); end
        n_tests++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL div0_no_timeout: got %b expected 0", timeout_err); end
        ex_div_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int waited; bit ok; bit hold_ok; logic [63:0] exp;
        @(negedge clk);
        drive_req(1'b0, 32'd50, 32'd8);
        exp_q.push_back({32'd2, 32'd6});
        wait_valid(60, waited, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (!ok || {hi_o, lo_o} !== exp)
            begin n_fail++; $display("FAIL b2b_first_result: got v=%b %h expected 1 %h", res_valid, {hi_o, lo_o}, exp); end
        pipe_stall = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || {hi_o, lo_o} !== exp || stallreq !== 1'b0) hold_ok = 1'b0;
        end
        n_tests++;
        if (!hold_ok) begin n_fail++; $display("FAIL stall_hold: got v=%b %h expected 1 %h", res_valid, {hi_o, lo_o}, exp); end
        pipe_stall = 1'b0;
        drive_req(1'b0, 32'd8, 32'd3);
        exp_q.push_back({32'd2, 32'd2});
        @(negedge clk);
        n_tests++;
        if ({div_start, res_valid, stallreq} !== 3'b001)
            begin n_fail++; $display("FAIL b2b_no_reraise: got start/v/stall %b expected 001", {div_start, res_valid, stallreq}); end
        @(negedge clk);
        n_tests++;
        if (div_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b expected 1", div_start); end
        wait_valid(60, waited, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (!ok || {hi_o, lo_o} !== exp)
            begin n_fail++; $display("FAIL b2b_second_result: got v=%b %h expected 1 %h", res_valid, {hi_o, lo_o}, exp); end
        ex_div_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        stub_hang = 1'b1;
        @(negedge clk);
        drive_req(1'b0, 32'd1, 32'd1);
        repeat (40) @(negedge clk);
        n_tests++;
        if ({timeout_err, stallreq} !== 2'b01)
            begin n_fail++; $display("FAIL tmo_early: got err/stall %b expected 01", {timeout_err, stallreq}); end
        repeat (20) @(negedge clk);
        n_tests++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b expected 1", timeout_err); end
        ex_div_req = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({timeout_err, stallreq} !== 2'b11)
            begin n_fail++; $display("FAIL tmo_sticky: got err/stall %b expected 11", {timeout_err, stallreq}); end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({timeout_err, div_start, stallreq} !== 3'b000)
            begin n_fail++; $display("FAIL tmo_async_reset: got err/start/stall %b expected 000", {timeout_err, div_start, stallreq}); end
        @(negedge clk);
        rst = 1'b1;
        stub_hang = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({timeout_err, div_start, stallreq, res_valid} !== 4'b0000)
            begin n_fail++; $display("FAIL tmo_idle_after_reset: got %b expected 0000", {timeout_err, div_start, stallreq, res_valid}); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_flush();
        test_div_zero();
        test_back_to_back();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
